// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner
// Upstream stage of the TS-to-AXI4-Stream packer. Hunts for the MPEG-TS sync
// byte at fixed packet spacing in a raw, unaligned byte stream, declares lock
// after LOCK_COUNT correctly spaced sync bytes, flywheels through isolated sync
// errors and emits packet-aligned bytes with ts_sync on packet byte 0.
//
// Ports:
//   ts_clk        byte clock, all logic on posedge
//   ts_aresetn    asynchronous active-low reset
//   in_valid      in_data carries a byte this cycle (gaps allowed)
//   in_data       raw TS byte
//   ts_valid      aligned byte valid (single-cycle qualifier)
//   ts_sync       high with ts_valid on packet byte 0
//   ts_data       aligned byte
//   locked        high while in LOCK
//   sync_miss_cnt missed sync bytes while locked   (TS_SYNC_STAT_EN only)
//   lock_loss_cnt LOCK->HUNT transitions           (TS_SYNC_STAT_EN only)
//
// Optional feature macro: TS_SYNC_STAT_EN (adds saturating statistics outputs).

module ts_sync_aligner #(
  parameter int unsigned MPEG_DATA_WIDTH = 8,
  parameter int unsigned PACK_BYTE_SIZE  = 188,
  parameter logic [7:0]  SYNC_BYTE       = 8'h47,
  parameter int unsigned LOCK_COUNT      = 3,
  parameter int unsigned UNLOCK_COUNT    = 3
) (
  input  logic                       ts_clk,
  input  logic                       ts_aresetn,
  input  logic                       in_valid,
  input  logic [MPEG_DATA_WIDTH-1:0] in_data,
  output logic                       ts_valid,
  output logic                       ts_sync,
  output logic [MPEG_DATA_WIDTH-1:0] ts_data,
  output logic                       locked
`ifdef TS_SYNC_STAT_EN
  ,
  output logic [15:0]                sync_miss_cnt,
  output logic [15:0]                lock_loss_cnt
`endif
);

  localparam int unsigned POS_W  = $clog2(PACK_BYTE_SIZE);
  localparam int unsigned GOOD_W = ($clog2(LOCK_COUNT) > 0) ? $clog2(LOCK_COUNT) : 1;
  localparam int unsigned MISS_W = ($clog2(UNLOCK_COUNT) > 0) ? $clog2(UNLOCK_COUNT) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PACK_BYTE_SIZE - 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d, pos_inc;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic is_sync;
  logic at_zero;
  logic lock_hit;   // this sync byte completes the confirmation run
  logic miss_last;  // this missed sync byte exhausts the flywheel
  logic emit;
  logic sync_o;
  logic miss_evt;
  logic loss_evt;

  assign is_sync   = (in_data == SYNC_BYTE);
  assign at_zero   = (pos_q == '0);
  assign pos_inc   = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
  // Counters only ever hold values below their limit: reaching the limit is
  // consumed immediately by the state change, so they saturate implicitly.
  assign lock_hit  = (32'(good_q) + 32'd1) >= LOCK_COUNT;
  assign miss_last = (32'(miss_q) + 32'd1) >= UNLOCK_COUNT;

  // State register
  always_ff @(posedge ts_clk or negedge ts_aresetn) begin
    if (!ts_aresetn) begin
      state_q <= HUNT;
      pos_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    good_d  = good_q;
    miss_d  = miss_q;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            pos_d   = POS_W'(1);
            good_d  = GOOD_W'(1);
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (at_zero) begin
            if (!is_sync) begin
              // The failing byte is not re-examined as a new candidate.
              state_d = HUNT;
              pos_d   = '0;
              good_d  = '0;
            end else if (lock_hit) begin
              state_d = LOCK;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
        end
        LOCK: begin
          pos_d = pos_inc;
          if (at_zero) begin
            if (is_sync) begin
              miss_d = '0;
            end else if (miss_last) begin
              state_d = HUNT;
              pos_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output decode
  always_comb begin
    emit     = 1'b0;
    sync_o   = 1'b0;
    miss_evt = 1'b0;
    loss_evt = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        VERIFY: begin
          if (at_zero && is_sync && lock_hit) begin
            emit   = 1'b1;
            sync_o = 1'b1;
          end
        end
        LOCK: begin
          if (at_zero && !is_sync) begin
            miss_evt = 1'b1;
            loss_evt = miss_last;
          end
          // The byte that breaks lock is dropped so no partial packet leaves.
          emit   = !(at_zero && !is_sync && miss_last);
          sync_o = at_zero;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge ts_clk or negedge ts_aresetn) begin
    if (!ts_aresetn) begin
      ts_valid <= 1'b0;
      ts_sync  <= 1'b0;
      ts_data  <= '0;
      locked   <= 1'b0;
    end else begin
      ts_valid <= emit;
      ts_sync  <= emit & sync_o;
      if (emit) begin
        ts_data <= in_data;
      end
      locked <= (state_d == LOCK);
    end
  end

`ifdef TS_SYNC_STAT_EN
  always_ff @(posedge ts_clk or negedge ts_aresetn) begin
    if (!ts_aresetn) begin
      sync_miss_cnt <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (miss_evt && (sync_miss_cnt != '1)) begin
        sync_miss_cnt <= sync_miss_cnt + 16'd1;
      end
      if (loss_evt && (lock_loss_cnt != '1)) begin
        lock_loss_cnt <= lock_loss_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt = miss_evt ^ loss_evt;
`endif

endmodule

// File: tb/tb_ts_sync_aligner.sv
module tb_ts_sync_aligner;

  localparam int PKT = 188;
  localparam int BIG = 1000000;

  logic       ts_clk;
  logic       ts_aresetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ts_valid;
  logic       ts_sync;
  logic [7:0] ts_data;
  logic       locked;
`ifdef TS_SYNC_STAT_EN
  logic [15:0] sync_miss_cnt;
  logic [15:0] lock_loss_cnt;
`endif

  ts_sync_aligner #(
    .MPEG_DATA_WIDTH(8),
    .PACK_BYTE_SIZE (188),
    .SYNC_BYTE      (8'h47),
    .LOCK_COUNT     (3),
    .UNLOCK_COUNT   (3)
  ) dut (
    .ts_clk       (ts_clk),
    .ts_aresetn   (ts_aresetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .ts_valid     (ts_valid),
    .ts_sync      (ts_sync),
    .ts_data      (ts_data),
    .locked       (locked)
`ifdef TS_SYNC_STAT_EN
    ,
    .sync_miss_cnt(sync_miss_cnt),
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  initial ts_clk = 1'b0;
  always #5 ts_clk = ~ts_clk;

  int checks = 0;
  int errors = 0;

  // Per-scenario accumulators
  int abs_idx;
  int emit_cnt;
  int sync_cnt;
  int byte_err;
  int first_emit_abs;
  int first_sync_abs;
  logic [31:0] bad_mask;

  function automatic logic [7:0] payload(input int i);
    logic [7:0] v;
    v = 8'((i * 29 + 11) % 256);
    if (v == 8'h47) v = 8'h46;
    return v;
  endfunction

  function automatic logic [7:0] junk(input int i);
    logic [7:0] v;
    v = 8'((i * 13 + 5) % 256);
    if (v == 8'h47) v = 8'h48;
    return v;
  endfunction

  // Stream byte i: sync at packet starts (0x00 for packets flagged bad).
  function automatic logic [7:0] sbyte(input int i);
    if (i % PKT == 0) return bad_mask[i / PKT] ? 8'h00 : 8'h47;
    return payload(i);
  endfunction

  task automatic clear_acc();
    abs_idx        = 0;
    emit_cnt       = 0;
    sync_cnt       = 0;
    byte_err       = 0;
    first_emit_abs = -1;
    first_sync_abs = -1;
  endtask

  task automatic reset_dut();
    in_valid   = 1'b0;
    in_data    = 8'h00;
    ts_aresetn = 1'b0;
    repeat (2) @(negedge ts_clk);
    ts_aresetn = 1'b1;
    @(negedge ts_clk);
    bad_mask = '0;
    clear_acc();
  endtask

  // One byte per 4 clocks; output sampled on the negedge after the accepting
  // posedge, then idle cycles must show ts_valid low.
  task automatic send_byte(input logic [7:0] b, input logic ev, input logic es,
                           input logic el);
    @(negedge ts_clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge ts_clk);
    in_valid = 1'b0;
    if (ts_valid === 1'b1) begin
      emit_cnt++;
      if (first_emit_abs < 0) first_emit_abs = abs_idx;
      if (ts_sync === 1'b1) begin
        sync_cnt++;
        if (first_sync_abs < 0) first_sync_abs = abs_idx;
      end
    end
    if ((ts_valid !== ev) || (locked !== el) ||
        (ev && ((ts_sync !== es) || (ts_data !== b))))
      byte_err++;
    repeat (2) begin
      @(negedge ts_clk);
      if (ts_valid !== 1'b0) byte_err++;
    end
    abs_idx++;
  endtask

  // Send stream bytes [first,last); emission expected for lock_idx <= i < stop_idx.
  task automatic run_range(input int first, input int last, input int lock_idx,
                           input int stop_idx);
    logic ev;
    for (int i = first; i < last; i++) begin
      ev = (i >= lock_idx) && (i < stop_idx);
      send_byte(sbyte(i), ev, ev && (i % PKT == 0), ev);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    ts_aresetn = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    repeat (3) @(negedge ts_clk);
    checks++;
    if ({ts_valid, ts_sync, ts_data, locked} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b expected=0", {ts_valid, ts_sync, ts_data, locked});
    end
`ifdef TS_SYNC_STAT_EN
    checks++;
    if ({sync_miss_cnt, lock_loss_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats actual=%h expected=0", {sync_miss_cnt, lock_loss_cnt});
    end
`endif
    reset_dut();
  endtask

  task automatic test_clean();
    reset_dut();
    run_range(0, 7 * PKT, 376, BIG);
    check_int("clean_byte_err", byte_err, 0);
    check_int("clean_emit_cnt", emit_cnt, 940);
    check_int("clean_sync_cnt", sync_cnt, 5);
    check_int("clean_first_sync", first_sync_abs, 376);
    check_int("clean_locked", int'(locked), 1);
  endtask

  task automatic test_junk_prefix();
    reset_dut();
    for (int j = 0; j < 5; j++) send_byte(junk(j), 1'b0, 1'b0, 1'b0);
    run_range(0, 7 * PKT, 376, BIG);
    check_int("junk_byte_err", byte_err, 0);
    check_int("junk_emit_cnt", emit_cnt, 940);
    check_int("junk_sync_cnt", sync_cnt, 5);
    check_int("junk_first_sync", first_sync_abs, 381);
  endtask

  task automatic test_false_sync();
    reset_dut();
    for (int o = 0; o < 300; o++)
      send_byte((o == 2) ? 8'h47 : junk(o), 1'b0, 1'b0, 1'b0);
    run_range(0, 7 * PKT, 376, BIG);
    check_int("false_byte_err", byte_err, 0);
    check_int("false_first_emit", first_emit_abs, 676);
    check_int("false_emit_cnt", emit_cnt, 940);
  endtask

  // Bad syncs at packets 3, 5, 6: stays locked only if packet 4 cleared miss_cnt.
  task automatic test_flywheel();
    reset_dut();
    bad_mask = 32'b0110_1000;
    run_range(0, 8 * PKT, 376, BIG);
    check_int("fly_byte_err", byte_err, 0);
    check_int("fly_emit_cnt", emit_cnt, 1128);
    check_int("fly_sync_cnt", sync_cnt, 6);
    check_int("fly_locked", int'(locked), 1);
`ifdef TS_SYNC_STAT_EN
    check_int("fly_sync_miss_cnt", int'(sync_miss_cnt), 3);
    check_int("fly_lock_loss_cnt", int'(lock_loss_cnt), 0);
`endif
  endtask

  task automatic test_lose_lock();
    reset_dut();
    bad_mask = 32'b0011_1000;
    run_range(0, 8 * PKT, 376, 940);
    check_int("loss_byte_err", byte_err, 0);
    check_int("loss_emit_cnt", emit_cnt, 564);
    check_int("loss_sync_cnt", sync_cnt, 3);
    check_int("loss_locked", int'(locked), 0);
`ifdef TS_SYNC_STAT_EN
    check_int("loss_sync_miss_cnt", int'(sync_miss_cnt), 3);
    check_int("loss_lock_loss_cnt", int'(lock_loss_cnt), 1);
`endif
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run_range(0, 476, 376, BIG);
    check_int("mid_pre_byte_err", byte_err, 0);
    // Packet byte 100 of the first locked packet
    @(negedge ts_clk);
    in_valid = 1'b1;
    in_data  = sbyte(476);
    @(negedge ts_clk);
    in_valid = 1'b0;
    check_int("mid_valid_before_reset", int'(ts_valid), 1);
    #1 ts_aresetn = 1'b0;
    #1;
    checks++;
    if ({ts_valid, ts_sync, ts_data, locked} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs actual=%b expected=0", {ts_valid, ts_sync, ts_data, locked});
    end
    @(negedge ts_clk);
    ts_aresetn = 1'b1;
    clear_acc();
    run_range(477, 7 * PKT, 940, BIG);
    check_int("mid_post_byte_err", byte_err, 0);
    check_int("mid_post_emit_cnt", emit_cnt, 376);
    check_int("mid_post_sync_cnt", sync_cnt, 2);
  endtask

  initial begin
    ts_aresetn = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    bad_mask   = '0;
    clear_acc();
    test_reset();
    test_clean();
    test_junk_prefix();
    test_false_sync();
    test_flywheel();
    test_lose_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
